// File: rtl/riscv_exec_alu_stage.sv
// RV32I integer ALU execute stage: decode into the E register, drive the
// external ALU, and queue results (2 deep) towards writeback.
package riscv_alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD              = 4'd0,
    ALU_SUB              = 4'd1,
    ALU_SHIFTL           = 4'd2,
    ALU_LESS_THAN_SIGNED = 4'd3,
    ALU_LESS_THAN        = 4'd4,
    ALU_XOR              = 4'd5,
    ALU_SHIFTR           = 4'd6,
    ALU_SHIFTR_ARITH     = 4'd7,
    ALU_OR               = 4'd8,
    ALU_AND              = 4'd9
  } alu_op_e;
endpackage

module riscv_exec_alu_stage
  import riscv_alu_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [6:0]              in_opcode_i,
  input  logic [2:0]              in_funct3_i,
  input  logic [6:0]              in_funct7_i,
  input  logic [31:0]             in_pc_i,
  input  logic [31:0]             in_rs1_val_i,
  input  logic [31:0]             in_rs2_val_i,
  input  logic [31:0]             in_imm_i,
  input  logic [4:0]              in_rd_i,
  output logic [3:0]              alu_op_o,
  output logic [31:0]             alu_a_o,
  output logic [31:0]             alu_b_o,
  input  logic [31:0]             alu_p_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4:0]              out_rd_o,
  output logic [31:0]             out_result_o,
  output logic                    out_wb_en_o,
  output logic                    out_illegal_o,
  output logic [RETIRE_CNT_W-1:0] retired_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic        e_valid;
  alu_op_e     e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [4:0]  e_rd;
  logic        e_wb_en;
  logic        e_illegal;

  logic [1:0]  cnt;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [4:0]  q_rd  [2];
  logic [31:0] q_res [2];
  logic        q_wb  [2];
  logic        q_ill [2];

  logic [RETIRE_CNT_W-1:0] retired;

  alu_op_e     d_op;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic        d_ill;
  logic        f7_zero;
  logic        f7_alt;
  logic        is_op;
  logic        is_opi;
  logic        is_lui;
  logic        is_auipc;

  logic accept;
  logic advance;
  logic push;
  logic pop;

  function automatic alu_op_e f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SHIFTL;
      3'b010: op = ALU_LESS_THAN_SIGNED;
      3'b011: op = ALU_LESS_THAN;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign is_op    = in_opcode_i == OPC_OP;
  assign is_opi   = in_opcode_i == OPC_OPIMM;
  assign is_lui   = in_opcode_i == OPC_LUI;
  assign is_auipc = in_opcode_i == OPC_AUIPC;
  assign f7_zero  = in_funct7_i == 7'b0000000;
  assign f7_alt   = in_funct7_i == 7'b0100000;

  always_comb begin
    d_op  = ALU_ADD;
    d_a   = '0;
    d_b   = '0;
    d_ill = 1'b0;
    unique case (1'b1)
      is_op: begin
        d_a  = in_rs1_val_i;
        d_b  = in_rs2_val_i;
        d_op = f3_op(in_funct3_i, f7_alt);
        if (!(f7_zero || f7_alt))
          d_ill = 1'b1;
        else if (f7_alt && in_funct3_i != 3'b000
                 && in_funct3_i != 3'b101)
          d_ill = 1'b1;
      end
      is_opi: begin
        d_a  = in_rs1_val_i;
        d_b  = in_imm_i;
        // funct7 is only meaningful on shifts; elsewhere it is imm bits
        d_op = f3_op(in_funct3_i,
                     in_funct3_i == 3'b101 && f7_alt);
        if (in_funct3_i == 3'b001 && !f7_zero)
          d_ill = 1'b1;
        if (in_funct3_i == 3'b101 && !(f7_zero || f7_alt))
          d_ill = 1'b1;
      end
      is_lui: begin
        d_b = in_imm_i;
      end
      is_auipc: begin
        d_a = in_pc_i;
        d_b = in_imm_i;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op = ALU_ADD;
      d_a  = '0;
      d_b  = '0;
    end
  end

  assign in_ready_o = !e_valid || !cnt[1];
  assign accept     = in_valid_i && in_ready_o;
  assign advance    = e_valid && !cnt[1];
  assign push       = advance;
  assign out_valid_o = cnt != 2'd0;
  assign pop        = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_valid   <= 1'b0;
      e_op      <= ALU_ADD;
      e_a       <= '0;
      e_b       <= '0;
      e_rd      <= '0;
      e_wb_en   <= 1'b0;
      e_illegal <= 1'b0;
    end else if (accept) begin
      e_valid   <= 1'b1;
      e_op      <= d_op;
      e_a       <= d_a;
      e_b       <= d_b;
      e_rd      <= in_rd_i;
      e_wb_en   <= !d_ill && in_rd_i != 5'd0;
      e_illegal <= d_ill;
    end else if (advance) begin
      e_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 2; i++) begin
        q_rd[i]  <= '0;
        q_res[i] <= '0;
        q_wb[i]  <= 1'b0;
        q_ill[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        q_rd[wr_ptr]  <= e_rd;
        q_res[wr_ptr] <= alu_p_i;
        q_wb[wr_ptr]  <= e_wb_en;
        q_ill[wr_ptr] <= e_illegal;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        retired <= retired + RETIRE_CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign alu_op_o      = e_op;
  assign alu_a_o       = e_a;
  assign alu_b_o       = e_b;
  assign out_rd_o      = q_rd[rd_ptr];
  assign out_result_o  = q_res[rd_ptr];
  assign out_wb_en_o   = q_wb[rd_ptr];
  assign out_illegal_o = q_ill[rd_ptr];
  assign retired_o     = retired;

endmodule

// File: tb/tb_riscv_exec_alu_stage.sv
// Random and directed bench for riscv_exec_alu_stage against a
// semantic RV32I reference model and an expected-result queue.
module tb_riscv_exec_alu_stage;
  import riscv_alu_pkg::*;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wb;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  in_opcode_i;
  logic [2:0]  in_funct3_i;
  logic [6:0]  in_funct7_i;
  logic [31:0] in_pc_i;
  logic [31:0] in_rs1_val_i;
  logic [31:0] in_rs2_val_i;
  logic [31:0] in_imm_i;
  logic [4:0]  in_rd_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_p_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  out_rd_o;
  logic [31:0] out_result_o;
  logic        out_wb_en_o;
  logic        out_illegal_o;
  logic [31:0] retired_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npop = 0;
  int stalls = 0;
  logic [31:0] exp_ret = '0;
  exp_t expq[$];
  int pop_cyc[$];
  exp_t last;
  logic rnd_rdy = 1'b0;

  riscv_exec_alu_stage #(.RETIRE_CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_opcode_i(in_opcode_i), .in_funct3_i(in_funct3_i),
    .in_funct7_i(in_funct7_i), .in_pc_i(in_pc_i),
    .in_rs1_val_i(in_rs1_val_i), .in_rs2_val_i(in_rs2_val_i),
    .in_imm_i(in_imm_i), .in_rd_i(in_rd_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_p_i(alu_p_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rd_o(out_rd_o), .out_result_o(out_result_o),
    .out_wb_en_o(out_wb_en_o), .out_illegal_o(out_illegal_o),
    .retired_o(retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external ALU
  always_comb begin
    alu_p_i = '0;
    case (alu_op_o)
      ALU_ADD:              alu_p_i = alu_a_o + alu_b_o;
      ALU_SUB:              alu_p_i = alu_a_o - alu_b_o;
      ALU_SHIFTL:           alu_p_i = alu_a_o << alu_b_o[4:0];
      ALU_LESS_THAN_SIGNED: alu_p_i = 32'($signed(alu_a_o) < $signed(alu_b_o));
      ALU_LESS_THAN:        alu_p_i = 32'(alu_a_o < alu_b_o);
      ALU_XOR:              alu_p_i = alu_a_o ^ alu_b_o;
      ALU_SHIFTR:           alu_p_i = alu_a_o >> alu_b_o[4:0];
      ALU_SHIFTR_ARITH:     alu_p_i = 32'($signed(alu_a_o) >>> alu_b_o[4:0]);
      ALU_OR:               alu_p_i = alu_a_o | alu_b_o;
      ALU_AND:              alu_p_i = alu_a_o & alu_b_o;
      default:              alu_p_i = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t ref_model(input instr_t t);
    exp_t e;
    logic [31:0] b;
    logic [31:0] res;
    logic ill;
    logic alt;
    logic isop;
    res = '0;
    ill = 1'b0;
    if (t.opc == 7'b0110011 || t.opc == 7'b0010011) begin
      isop = t.opc == 7'b0110011;
      b = isop ? t.rs2 : t.imm;
      alt = t.f7 == 7'h20;
      if (isop)
        ill = !(t.f7 == 7'h00 || alt) ||
              (alt && t.f3 != 3'd0 && t.f3 != 3'd5);
      else
        ill = (t.f3 == 3'd1 && t.f7 != 7'h00) ||
              (t.f3 == 3'd5 && t.f7 != 7'h00 && !alt);
      case (t.f3)
        3'd0: res = (isop && alt) ? t.rs1 - b : t.rs1 + b;
        3'd1: res = t.rs1 << b[4:0];
        3'd2: res = ($signed(t.rs1) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (t.rs1 < b) ? 32'd1 : 32'd0;
        3'd4: res = t.rs1 ^ b;
        3'd5: res = alt ? 32'($signed(t.rs1) >>> b[4:0])
                        : t.rs1 >> b[4:0];
        3'd6: res = t.rs1 | b;
        default: res = t.rs1 & b;
      endcase
    end else if (t.opc == 7'b0110111) begin
      res = t.imm;
    end else if (t.opc == 7'b0010111) begin
      res = t.pc + t.imm;
    end else begin
      ill = 1'b1;
    end
    if (ill) res = '0;
    e.rd  = t.rd;
    e.res = res;
    e.ill = ill;
    e.wb  = !ill && t.rd != 5'd0;
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] opc,
      input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] pc, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [31:0] imm,
      input logic [4:0] rd);
    instr_t t;
    t.opc = opc; t.f3 = f3; t.f7 = f7; t.pc = pc;
    t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.rd = rd;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    int s;
    logic [31:0] r;
    k = $urandom_range(0, 9);
    s = $urandom_range(0, 3);
    r = $urandom;
    t.f3  = 3'($urandom_range(0, 7));
    t.f7  = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 :
            (s == 2) ? 7'h01 : 7'($urandom_range(0, 127));
    t.pc  = $urandom;
    t.rs1 = $urandom;
    t.rs2 = $urandom;
    t.rd  = 5'($urandom_range(0, 31));
    t.imm = $urandom;
    if (k <= 3) t.opc = 7'b0110011;
    else if (k <= 6) begin
      t.opc = 7'b0010011;
      t.imm = {{20{t.f7[6]}}, t.f7, r[4:0]};
    end else if (k == 7) begin
      t.opc = 7'b0110111;
      t.imm = {r[19:0], 12'h000};
    end else if (k == 8) begin
      t.opc = 7'b0010111;
      t.imm = {r[19:0], 12'h000};
    end else t.opc = 7'($urandom_range(0, 127));
    return t;
  endfunction

  // monitor: samples on the falling edge, pops happen on the next rise
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_i) begin
      expq.delete();
      exp_ret = '0;
    end else begin
      check("retired", retired_o, exp_ret);
      if (out_valid_o && out_ready_i) begin
        if (expq.size() == 0) begin
          check("spurious_pop", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("rd", 32'(out_rd_o), 32'(e.rd));
          check("result", out_result_o, e.res);
          check("wb_en", 32'(out_wb_en_o), 32'(e.wb));
          check("illegal", 32'(out_illegal_o), 32'(e.ill));
        end
        last.rd  = out_rd_o;
        last.res = out_result_o;
        last.wb  = out_wb_en_o;
        last.ill = out_illegal_o;
        exp_ret++;
        npop++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input instr_t t);
    int g;
    g = 0;
    in_valid_i   = 1'b1;
    in_opcode_i  = t.opc;
    in_funct3_i  = t.f3;
    in_funct7_i  = t.f7;
    in_pc_i      = t.pc;
    in_rs1_val_i = t.rs1;
    in_rs2_val_i = t.rs2;
    in_imm_i     = t.imm;
    in_rd_i      = t.rd;
    while (!in_ready_o && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    stalls += g;
    if (!in_ready_o) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    expq.push_back(ref_model(t));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int p0;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    in_opcode_i = '0; in_funct3_i = '0; in_funct7_i = '0;
    in_pc_i = '0; in_rs1_val_i = '0; in_rs2_val_i = '0;
    in_imm_i = '0; in_rd_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_alu_op", 32'(alu_op_o), 32'(ALU_ADD));
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_b", alu_b_o, 32'd0);
    check("rst_out_rd", 32'(out_rd_o), 32'd0);
    check("rst_result", out_result_o, 32'd0);
    check("rst_wb_en", 32'(out_wb_en_o), 32'd0);
    check("rst_illegal", 32'(out_illegal_o), 32'd0);
    check("rst_retired", retired_o, 32'd0);
    rst_i = 1'b0;

    // single ADDI, two-edge latency
    out_ready_i = 1'b1;
    send(mk(7'b0010011, 3'd0, 7'h7F, 0, 32'd5, 0, 32'hFFFF_FFFD, 5'd3));
    check("addi_lat1_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk); #1;
    check("addi_valid", 32'(out_valid_o), 32'd1);
    check("addi_result", out_result_o, 32'd2);
    check("addi_rd", 32'(out_rd_o), 32'd3);
    check("addi_wb", 32'(out_wb_en_o), 32'd1);
    check("addi_ill", 32'(out_illegal_o), 32'd0);
    @(posedge clk); #1;
    check("addi_retired", retired_o, 32'd1);

    // shifts right
    send(mk(7'b0010011, 3'd5, 7'h20, 0, 32'h8000_0010, 0, 32'h404, 5'd7));
    drain();
    check("srai", last.res, 32'hF800_0001);
    send(mk(7'b0010011, 3'd5, 7'h00, 0, 32'h8000_0010, 0, 32'h004, 5'd7));
    drain();
    check("srli", last.res, 32'h0800_0001);

    // back-pressure: 3 held, 4th blocked until writeback drains
    out_ready_i = 1'b0;
    p0 = npop;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(mk(7'b0110011, 3'd0, 7'h00, 0, 32'(i * 10),
                  32'd1, 0, 5'(i + 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready", 32'(in_ready_o), 32'd0);
        check("bp_out_valid", 32'(out_valid_o), 32'd1);
        check("bp_queued", 32'(expq.size()), 32'd3);
        out_ready_i = 1'b1;
      end
    join
    drain();
    check("bp_pops", 32'(npop - p0), 32'd4);

    // full-speed stream
    out_ready_i = 1'b1;
    p0 = npop;
    stalls = 0;
    pop_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(mk(7'b0110011, 3'd0, 7'h00, 0, $urandom, $urandom,
              0, 5'(i + 8)));
    drain();
    check("fs_pops", 32'(npop - p0), 32'd8);
    check("fs_stalls", 32'(stalls), 32'd0);
    if (pop_cyc.size() == 8)
      check("fs_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    else
      check("fs_popcnt", 32'(pop_cyc.size()), 32'd8);

    // illegal encodings
    send(mk(7'b0110011, 3'd0, 7'h01, 0, 32'd7, 32'd9, 0, 5'd4));
    drain();
    check("ill_m_ill", 32'(last.ill), 32'd1);
    check("ill_m_wb", 32'(last.wb), 32'd0);
    check("ill_m_res", last.res, 32'd0);
    send(mk(7'b0000011, 3'd2, 7'h00, 0, 32'd7, 32'd9, 32'd4, 5'd5));
    drain();
    check("ill_ld_ill", 32'(last.ill), 32'd1);
    check("ill_ld_res", last.res, 32'd0);
    send(mk(7'b0110111, 3'd0, 7'h00, 0, 0, 0, 32'h1234_5000, 5'd0));
    drain();
    check("lui_x0_wb", 32'(last.wb), 32'd0);
    check("lui_x0_ill", 32'(last.ill), 32'd0);

    // random traffic with random writeback back-pressure
    rnd_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) send(rand_instr());
        rnd_rdy = 1'b0;
      end
      begin
        while (rnd_rdy) begin
          @(posedge clk); #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready_i = 1'b1;
    drain();

    // reset with two entries queued and one in E
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      send(mk(7'b0110011, 3'd4, 7'h00, 0, $urandom, $urandom,
              0, 5'd6));
    @(posedge clk); #1;
    check("pre_rst_in_ready", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_ready", 32'(in_ready_o), 32'd1);
    check("mid_rst_retired", retired_o, 32'd0);
    out_ready_i = 1'b1;
    send(mk(7'b0010111, 3'd0, 7'h00, 32'h100, 0, 0, 32'h1000, 5'd9));
    drain();
    check("auipc", last.res, 32'h0000_1100);
    @(posedge clk); #1;
    check("final_retired", retired_o, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
